// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// with a fixed request-accept to response latency of 64/BITS_PER_CYCLE + 1 cycles.
module mdu_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data
);

  localparam int         N        = 64 / BITS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT = 6'(N - 1);

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULW  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_REM   = 4'd4;
  localparam logic [3:0] OP_REMU  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_DIVUW = 4'd7;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [3:0]  op_r;
  logic        prep_r;
  logic [5:0]  cnt_r;
  logic [63:0] acc_r, x_r, y_r;
  logic        q_neg_r, r_neg_r;
  logic        resp_valid_r;
  logic [63:0] resp_data_r;

  logic        accept_s, last_s, is_mul_s, is_w_s, is_signed_s;
  logic        a_neg_s, b_neg_s;
  logic [63:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s;
  logic [63:0] acc_s, x_s, y_s, quo_s, rem_s, res_s;
  logic [64:0] rem_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign accept_s   = (state_r == IDLE) && req_valid && !flush;
  assign last_s     = (state_r == BUSY) && !prep_r && (cnt_r == LAST_CNT);
  assign is_mul_s   = (op_r == OP_MUL) || (op_r == OP_MULW);

  // Operand class decode and conversion to magnitudes for the preparation cycle
  always_comb begin
    is_w_s      = 1'b0;
    is_signed_s = 1'b0;
    case (op_r)
      OP_MULW, OP_DIVUW, OP_REMUW: is_w_s = 1'b1;
      OP_DIVW, OP_REMW: begin
        is_w_s      = 1'b1;
        is_signed_s = 1'b1;
      end
      OP_DIV, OP_REM: is_signed_s = 1'b1;
      default: is_w_s = 1'b0;
    endcase
    if (is_w_s) begin
      a_ext_s = is_signed_s ? sext32(x_r[31:0]) : {32'd0, x_r[31:0]};
      b_ext_s = is_signed_s ? sext32(y_r[31:0]) : {32'd0, y_r[31:0]};
    end else begin
      a_ext_s = x_r;
      b_ext_s = y_r;
    end
    a_neg_s = is_signed_s & a_ext_s[63];
    b_neg_s = is_signed_s & b_ext_s[63];
    a_mag_s = a_neg_s ? (64'd0 - a_ext_s) : a_ext_s;
    b_mag_s = b_neg_s ? (64'd0 - b_ext_s) : b_ext_s;
  end

  // One cycle worth of shift-add or restoring-divide steps
  always_comb begin
    acc_s = acc_r;
    x_s   = x_r;
    y_s   = y_r;
    rem_t = 65'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_mul_s) begin
        if (y_s[0]) acc_s = acc_s + x_s;
        else        acc_s = acc_s;
        x_s = {x_s[62:0], 1'b0};
        y_s = {1'b0, y_s[63:1]};
      end else begin
        rem_t = {acc_s, x_s[63]};
        x_s   = {x_s[62:0], 1'b0};
        if (rem_t >= {1'b0, y_s}) begin
          rem_t  = rem_t - {1'b0, y_s};
          x_s[0] = 1'b1;
        end else begin
          rem_t = rem_t;
        end
        acc_s = rem_t[63:0];
      end
    end
  end

  // Sign restoration and result selection from the final iteration values
  always_comb begin
    quo_s = q_neg_r ? (64'd0 - x_s) : x_s;
    rem_s = r_neg_r ? (64'd0 - acc_s) : acc_s;
    case (op_r)
      OP_MUL:             res_s = acc_s;
      OP_MULW:            res_s = sext32(acc_s[31:0]);
      OP_DIV, OP_DIVU:    res_s = quo_s;
      OP_REM, OP_REMU:    res_s = rem_s;
      OP_DIVW, OP_DIVUW:  res_s = sext32(quo_s[31:0]);
      OP_REMW, OP_REMUW:  res_s = sext32(rem_s[31:0]);
      default:            res_s = 64'd0;
    endcase
  end

  // Next-state selection; flush overrides every other transition
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (req_valid)  state_s = BUSY; else state_s = IDLE;
        BUSY:    if (last_s)     state_s = DONE; else state_s = BUSY;
        DONE:    if (resp_ready) state_s = IDLE; else state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Operand capture, conditioning, iteration and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r         <= 4'd0;
      prep_r       <= 1'b0;
      cnt_r        <= 6'd0;
      acc_r        <= 64'd0;
      x_r          <= 64'd0;
      y_r          <= 64'd0;
      q_neg_r      <= 1'b0;
      r_neg_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 64'd0;
    end else begin
      if (accept_s) begin
        op_r   <= req_op;
        x_r    <= req_a;
        y_r    <= req_b;
        acc_r  <= 64'd0;
        prep_r <= 1'b1;
        cnt_r  <= 6'd0;
      end else if ((state_r == BUSY) && prep_r) begin
        // Divide by zero keeps the all-ones quotient unsigned
        x_r     <= a_mag_s;
        y_r     <= b_mag_s;
        acc_r   <= 64'd0;
        q_neg_r <= (a_neg_s ^ b_neg_s) & (b_ext_s != 64'd0);
        r_neg_r <= a_neg_s;
        prep_r  <= 1'b0;
      end else if (state_r == BUSY) begin
        x_r   <= x_s;
        y_r   <= y_s;
        acc_r <= acc_s;
        cnt_r <= cnt_r + 6'd1;
      end
      if (last_s && !flush) resp_data_r <= res_s;
      resp_valid_r <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV64M corner cases, randomized ops against an
// arithmetic reference model, latency, back-pressure, flush and reset behaviour.
module tb_mdu_iter;

  localparam int LAT1 = 65;
  localparam int LAT4 = 17;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, resp_ready, req_valid4;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        req_ready, resp_valid, req_ready4, resp_valid4;
  logic [63:0] resp_data, resp_data4;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mdu_iter #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  mdu_iter #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid4), .resp_ready(1'b1), .resp_data(resp_data4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics written directly with language arithmetic
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    int sx, sy;
    int unsigned ux, uy;
    logic [63:0] r;
    logic [31:0] w;
    sa = a; sb = b; sx = a[31:0]; sy = b[31:0]; ux = a[31:0]; uy = b[31:0];
    r = 64'd0; w = 32'd0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin r = a * b; w = r[31:0]; r = {{32{w[31]}}, w}; end
      4'd2: begin
        if (b == 64'd0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = sa / sb;
      end
      4'd3: begin if (b == 64'd0) r = '1; else r = a / b; end
      4'd4: begin
        if (b == 64'd0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 64'd0;
        else r = sa % sb;
      end
      4'd5: begin if (b == 64'd0) r = a; else r = a % b; end
      4'd6, 4'd8: begin
        if (sy == 0) w = (op == 4'd6) ? 32'hFFFF_FFFF : a[31:0];
        else if (sx == 32'sh8000_0000 && sy == -1) w = (op == 4'd6) ? 32'h8000_0000 : 32'd0;
        else if (op == 4'd6) w = sx / sy;
        else w = sx % sy;
        r = {{32{w[31]}}, w};
      end
      4'd7, 4'd9: begin
        if (uy == 0) w = (op == 4'd7) ? 32'hFFFF_FFFF : a[31:0];
        else if (op == 4'd7) w = ux / uy;
        else w = ux % uy;
        r = {{32{w[31]}}, w};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {32'd0, $urandom};
      4: return {32'hFFFF_FFFF, 32'h8000_0000};
      5: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
  endtask

  task automatic txn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                     output logic [63:0] data, output int lat);
    issue(op, a, b);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    data = resp_data;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp);
    logic [63:0] d;
    int lat;
    txn(op, a, b, d, lat);
    check({tag, "_data"}, d, exp);
    check({tag, "_lat"}, 64'(lat), 64'(LAT1));
    @(negedge clk);
    check({tag, "_vdrop"}, 64'(resp_valid), 64'd0);
  endtask

  task automatic run4(input string tag, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    req_valid4 = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid4 = 1'b0;
    lat = 0;
    while (resp_valid4 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_data"}, resp_data4, exp);
    check({tag, "_lat"}, 64'(lat), 64'(LAT4));
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d, a, b;
    logic [3:0] op;
    int lat, seen;

    reset = 1'b1; req_valid = 1'b1; req_valid4 = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    req_op = 4'd0; req_a = 64'd5; req_b = 64'd7;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_data", resp_data, 64'd0);
    check("rst_valid4", 64'(resp_valid4), 64'd0);
    check("rst_ready4", 64'(req_ready4), 64'd1);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);

    run("mul_m1x3", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    run("div_m7_2", 4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run("rem_m7_2", 4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divu_100_7", 4'd3, 64'd100, 64'd7, 64'd14);
    run("remu_100_7", 4'd5, 64'd100, 64'd7, 64'd2);
    run("divu_by0", 4'd3, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run("rem_by0", 4'd4, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
    run("div_ovf", 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    run("remw_ovf", 4'd8, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
    run("divw_ovf", 4'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    run("mulw", 4'd1, 64'h1_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000);
    run("divuw", 4'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF);
    run("divw", 4'd6, 64'h1_0000_000A, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFB);
    run("remuw_by0", 4'd9, 64'h8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001);
    run("illegal", 4'd12, 64'd9, 64'd3, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15)); a = pick(); b = pick();
      run($sformatf("rnd%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end

    run4("w4_mul", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 9)); a = pick(); b = pick();
      run4($sformatf("w4_rnd%0d_op%0d", i, op), op, a, b, model(op, a, b));
    end

    // Back-pressure: response held while the consumer stalls
    resp_ready = 1'b0;
    txn(4'd3, 64'd100, 64'd7, d, lat);
    check("bp_data", d, 64'd14);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), resp_data, 64'd14);
      check($sformatf("bp_nordy%0d", k), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_vdrop", 64'(resp_valid), 64'd0);
    check("bp_ready", 64'(req_ready), 64'd1);

    // Flush in BUSY, then a request presented together with flush
    issue(4'd0, 64'd11, 64'd13);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy_v", 64'(resp_valid), 64'd0);
    check("fl_busy_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("fl_noacc", 64'(req_ready), 64'd1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    check("fl_busy_nopulse", 64'(seen), 64'd0);

    // Flush in DONE while the consumer stalls
    resp_ready = 1'b0;
    txn(4'd3, 64'd100, 64'd7, d, lat);
    check("fl_done_pre", d, 64'd14);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b1;
    check("fl_done_v", 64'(resp_valid), 64'd0);
    check("fl_done_idle", 64'(req_ready), 64'd1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    check("fl_done_nopulse", 64'(seen), 64'd0);

    // Reset mid-BUSY clears outputs at once
    issue(4'd0, 64'd3, 64'd5);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rb_valid", 64'(resp_valid), 64'd0);
    check("rb_data", resp_data, 64'd0);
    check("rb_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    run("mul_6x7", 4'd0, 64'd6, 64'd7, 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
